// File: rtl/noc_arb_pkg.sv
// rtl/noc_arb_pkg.sv - shared types, constants and round-robin search for the output-port arbiter
//   PORT_L..PORT_S : conventional input indices of the 5-port router
//   HEAD_ID_DEF    : default flit_id value that marks a header flit
//   arb_state_t    : IDLE (no owner) / OWN (one input holds the grant)
//   rr_search      : first requester after a start index, wrapping, optionally including the start
package noc_arb_pkg;

  localparam int PORT_L      = 0;
  localparam int PORT_N      = 1;
  localparam int PORT_E      = 2;
  localparam int PORT_W      = 3;
  localparam int PORT_S      = 4;
  localparam int HEAD_ID_DEF = 1;
  localparam int MAX_PORTS   = 32;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Returns the index of the first set bit of req visiting s+1, s+2, ... mod n.
  // The start index itself is visited last, and only when incl_self is set.
  // Returns -1 when no eligible requester exists. Scanning from the far end
  // lets the closest hit overwrite the result, giving a fixed-bound loop.
  function automatic int rr_search(input logic [MAX_PORTS-1:0] req, input int s,
                                   input int n, input logic incl_self);
    int idx;
    rr_search = -1;
    for (int k = MAX_PORTS; k >= 1; k--) begin
      idx = (s + k) % n;
      if ((k < n || (k == n && incl_self)) && req[idx[4:0]])
        rr_search = idx;
    end
  endfunction

endpackage

// File: rtl/arb_port_timer.sv
// rtl/arb_port_timer.sv - per-input tenure limit latch, tenure counter and time-up flag
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-low reset
//   flit_id  in  this input's flit id; HEAD_ID latches a new limit
//   length   in  tenure limit in cycles (0 = unlimited)
//   owner    in  this input currently holds the registered grant
//   timesup  out tenure ends at the coming edge
module arb_port_timer #(
  parameter int LEN_W   = 12,
  parameter int FID_W   = 3,
  parameter int HEAD_ID = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FID_W-1:0] flit_id,
  input  logic [LEN_W-1:0] length,
  input  logic             owner,
  output logic             timesup
);

  logic [LEN_W-1:0] limit_q;
  logic [LEN_W-1:0] count_q;
  logic [LEN_W:0]   count_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      limit_q <= '0;
      count_q <= '0;
    end else begin
      if (flit_id == FID_W'(HEAD_ID))
        limit_q <= length;
      if (!owner)
        count_q <= '0;
      else if (count_q != '1)
        count_q <= count_q + LEN_W'(1);
    end
  end

  // One extra bit so count+1 cannot wrap at the top of the counter range.
  assign count_inc = {1'b0, count_q} + (LEN_W + 1)'(1);
  assign timesup   = (limit_q != '0) && (count_inc >= {1'b0, limit_q});

endmodule

// File: rtl/noc_rr_timeout_arbiter.sv
// rtl/noc_rr_timeout_arbiter.sv - round-robin output-port arbiter with per-input grant-tenure timeout
//   Build option: ARB_TIMEOUT_EN enables the per-input tenure timers.
//   clk       in  clock, rising edge
//   rst       in  asynchronous active-low reset
//   flit_id   in  per-input flit id, input i at [i*FID_W +: FID_W]
//   length    in  per-input tenure limit, input i at [i*LEN_W +: LEN_W]
//   req       in  per-input request
//   grant     out registered one-hot grant, zero when idle
//   grant_id  out index of granted input, zero when idle
//   busy      out any grant active
module noc_rr_timeout_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NPORTS  = 5,
  parameter int LEN_W   = 12,
  parameter int FID_W   = 3,
  parameter int HEAD_ID = HEAD_ID_DEF,
  localparam int PW     = $clog2(NPORTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORTS*FID_W-1:0] flit_id,
  input  logic [NPORTS*LEN_W-1:0] length,
  input  logic [NPORTS-1:0]       req,
  output logic [NPORTS-1:0]       grant,
  output logic [PW-1:0]           grant_id,
  output logic                    busy
);

  arb_state_t            state, state_n;
  logic [PW-1:0]         ptr, ptr_n;
  logic [NPORTS-1:0]     grant_n;
  logic [PW-1:0]         grant_id_n;
  logic [NPORTS-1:0]     timesup;
  logic [MAX_PORTS-1:0]  req_ext;
  logic                  hold;
  int                    found;

`ifdef ARB_TIMEOUT_EN
  for (genvar i = 0; i < NPORTS; i++) begin : g_timer
    arb_port_timer #(
      .LEN_W   (LEN_W),
      .FID_W   (FID_W),
      .HEAD_ID (HEAD_ID)
    ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .flit_id (flit_id[i*FID_W +: FID_W]),
      .length  (length[i*LEN_W +: LEN_W]),
      .owner   (grant[i]),
      .timesup (timesup[i])
    );
  end
`else
  // Without timers the owner keeps the grant for as long as it requests.
  logic unused_cfg;
  assign unused_cfg = ^{flit_id, length};
  assign timesup    = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      ptr      <= PW'(NPORTS - 1);
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      grant_id <= grant_id_n;
      ptr      <= ptr_n;
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    grant_id_n = grant_id;
    ptr_n      = ptr;
    hold       = 1'b0;
    found      = -1;
    req_ext    = '0;
    req_ext[NPORTS-1:0] = req;

    case (state)
      IDLE: begin
        if (|req) begin
          found      = rr_search(req_ext, int'(ptr), NPORTS, 1'b1);
          state_n    = OWN;
          grant_n    = {{(NPORTS-1){1'b0}}, 1'b1} << found[PW-1:0];
          grant_id_n = found[PW-1:0];
          ptr_n      = found[PW-1:0];
        end
      end
      OWN: begin
        hold = req[grant_id] && !timesup[grant_id];
        if (!hold) begin
          // The releasing owner is excluded so others are served first;
          // it can only come back through IDLE.
          found = rr_search(req_ext, int'(grant_id), NPORTS, 1'b0);
          if (found >= 0) begin
            grant_n    = {{(NPORTS-1){1'b0}}, 1'b1} << found[PW-1:0];
            grant_id_n = found[PW-1:0];
            ptr_n      = found[PW-1:0];
          end else begin
            state_n    = IDLE;
            grant_n    = '0;
            grant_id_n = '0;
          end
        end
      end
      default: begin
        state_n    = IDLE;
        grant_n    = '0;
        grant_id_n = '0;
      end
    endcase
  end

  assign busy = |grant;

endmodule

// File: tb/tb_noc_rr_timeout_arbiter.sv
// tb/tb_noc_rr_timeout_arbiter.sv - scoreboard bench for noc_rr_timeout_arbiter
module tb_noc_rr_timeout_arbiter;

  localparam int NPORTS = 5;
  localparam int LEN_W  = 12;
  localparam int FID_W  = 3;
  localparam int PW     = 3;

  localparam logic [NPORTS*FID_W-1:0] FID_NONE = '0;
  localparam logic [NPORTS*LEN_W-1:0] LEN_ZERO = '0;
  localparam logic [NPORTS*FID_W-1:0] FID_HEAD = {5{3'd1}};

  logic                    clk;
  logic                    rst;
  logic [NPORTS*FID_W-1:0] flit_id;
  logic [NPORTS*LEN_W-1:0] length;
  logic [NPORTS-1:0]       req;
  logic [NPORTS-1:0]       grant;
  logic [PW-1:0]           grant_id;
  logic                    busy;

  int checks = 0;
  int errors = 0;
  logic [NPORTS-1:0] exp_q[$];

  noc_rr_timeout_arbiter #(
    .NPORTS (NPORTS),
    .LEN_W  (LEN_W),
    .FID_W  (FID_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flit_id  (flit_id),
    .length   (length),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] idx_of(input logic [NPORTS-1:0] g);
    idx_of = '0;
    for (int i = 0; i < NPORTS; i++)
      if (g[i]) idx_of = PW'(i);
  endfunction

  // Drive one cycle of inputs and queue the grant expected after the next edge.
  task automatic drive(input logic [NPORTS-1:0] r, input logic [NPORTS*FID_W-1:0] f,
                       input logic [NPORTS*LEN_W-1:0] l, input logic [NPORTS-1:0] exp_g);
    @(negedge clk);
    req     = r;
    flit_id = f;
    length  = l;
    exp_q.push_back(exp_g);
  endtask

  // Monitor: structural invariants every cycle, scoreboard pop when an expectation is queued.
  always @(posedge clk) begin
    logic [NPORTS-1:0] e;
    #1;
    chk("onehot0", 32'($onehot0(grant)), 32'd1);
    chk("id_consistent", 32'(grant_id), 32'(idx_of(grant)));
    chk("busy", 32'(busy), 32'(|grant));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("grant", 32'(grant), 32'(e));
      chk("grant_id", 32'(grant_id), 32'(idx_of(e)));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; req = '0; flit_id = FID_NONE; length = LEN_ZERO;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_id", 32'(grant_id), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b1;

    // L and N request with unlimited tenure: L wins and never moves.
    for (int i = 0; i < 6; i++) drive(5'b00011, FID_NONE, LEN_ZERO, 5'b00001);
    // L drops while E and S request: E next, then S after E releases.
    drive(5'b10100, FID_NONE, LEN_ZERO, 5'b00100);
    drive(5'b10100, FID_NONE, LEN_ZERO, 5'b00100);
    drive(5'b10000, FID_NONE, LEN_ZERO, 5'b10000);
    drive(5'b00000, FID_NONE, LEN_ZERO, 5'b00000);
    drive(5'b00000, FID_NONE, LEN_ZERO, 5'b00000);
    // From IDLE with ptr=S: L first; then rotation on each release.
    drive(5'b11111, FID_NONE, LEN_ZERO, 5'b00001);
    drive(5'b11111, FID_NONE, LEN_ZERO, 5'b00001);
    drive(5'b11110, FID_NONE, LEN_ZERO, 5'b00010);
    drive(5'b11100, FID_NONE, LEN_ZERO, 5'b00100);
    drive(5'b00011, FID_NONE, LEN_ZERO, 5'b00001);
    drive(5'b00001, FID_NONE, LEN_ZERO, 5'b00001);

    // Asynchronous reset mid-tenure, then S wins from the reset pointer.
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_reset_grant", 32'(grant), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1; req = '0;
    drive(5'b10000, FID_NONE, LEN_ZERO, 5'b10000);
    drive(5'b00000, FID_NONE, LEN_ZERO, 5'b00000);

`ifdef ARB_TIMEOUT_EN
    // Reset to pointer S, load limit 3 everywhere, then rotate 3 cycles each.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    drive(5'b00000, FID_HEAD, {5{12'd3}}, 5'b00000);
    for (int p = 0; p < 6; p++)
      for (int c = 0; c < 3; c++)
        drive(5'b11111, FID_NONE, LEN_ZERO, 5'b00001 << (p % 5));
    drive(5'b00000, FID_NONE, LEN_ZERO, 5'b00000);
    // Single requester L with limit 2: two cycles granted, one idle, repeat.
    drive(5'b00000, {12'd0, 3'd1}, {48'd0, 12'd2}, 5'b00000);
    for (int r = 0; r < 3; r++) begin
      drive(5'b00001, FID_NONE, LEN_ZERO, 5'b00001);
      drive(5'b00001, FID_NONE, LEN_ZERO, 5'b00001);
      drive(5'b00001, FID_NONE, LEN_ZERO, 5'b00000);
    end
    drive(5'b00000, FID_NONE, LEN_ZERO, 5'b00000);
`else
    // Header flits with length 1 are ignored: L keeps the grant.
    for (int i = 0; i < 8; i++) drive(5'b11111, FID_HEAD, {5{12'd1}}, 5'b00001);
    drive(5'b00000, FID_NONE, LEN_ZERO, 5'b00000);
`endif

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
